rob_controller: RTL

Reorder-buffer occupancy controller for the P6-style out-of-order core. Owns the ROB head/tail pointers, hands out an entry tag to each dispatched instruction, retires entries in order at commit, and squashes younger entries on a branch mispredict or exception. It produces the `rob_full` signal that the hazard detection logic uses to stall the frontend, and it holds allocation off during a post-flush recovery window.

---
 rtl/rob_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rob_controller.sv
// Reorder-buffer occupancy controller: head/tail pointers with wrap bit, in-order
// alloc/commit, partial/full flush with recovery window. Optional: ROB_ALMOST_FULL_EN.
module rob_controller #(
    parameter int ROB_DEPTH      = 16,
    parameter int TAG_W          = $clog2(ROB_DEPTH),
    parameter int RECOVER_CYCLES = 2,
    parameter int AF_MARGIN      = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             alloc_req_i,
    output logic             alloc_ok_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             commit_req_i,
    output logic             commit_ok_o,
    output logic [TAG_W-1:0] commit_tag_o,
    input  logic             flush_i,
    input  logic             flush_all_i,
    input  logic [TAG_W-1:0] flush_tag_i,
    output logic             rob_full_o,
    output logic             rob_empty_o,
    output logic [TAG_W:0]   rob_count_o,
    output logic             recovering_o
`ifdef ROB_ALMOST_FULL_EN
    ,
    output logic             rob_almost_full_o
`endif
);

    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);
    localparam logic [3:0]     RCNT_LD = 4'(RECOVER_CYCLES - 1);

    typedef enum logic {RUN, RECOVER} state_e;

    state_e         state_q;
    logic [3:0]     rcnt_q;
    logic           recovering_q;
    logic [TAG_W:0] head_q, head_d;
    logic [TAG_W:0] tail_q, tail_d;
    logic [TAG_W:0] count_d;
    logic [TAG_W-1:0] keep_off;

    // Status comes from registered pointers only; grants are combinational.
    assign rob_count_o  = tail_q - head_q;
    assign rob_full_o   = (rob_count_o == DEPTH_C);
    assign rob_empty_o  = (rob_count_o == '0);
    assign alloc_tag_o  = tail_q[TAG_W-1:0];
    assign commit_tag_o = head_q[TAG_W-1:0];
    assign recovering_o = recovering_q;

    assign alloc_ok_o  = alloc_req_i && !rob_full_o && (state_q == RUN) && !flush_i;
    assign commit_ok_o = commit_req_i && !rob_empty_o;

    // Distance from head to the last survivor; modulo arithmetic keeps the wrap bit right.
    assign keep_off = flush_tag_i - head_q[TAG_W-1:0];

    always_comb begin
        head_d = head_q + (TAG_W+1)'(commit_ok_o);
        tail_d = tail_q + (TAG_W+1)'(alloc_ok_o);
        if (flush_i) begin
            if (flush_all_i) tail_d = head_d;
            else             tail_d = head_q + (TAG_W+1)'(keep_off) + PTR_ONE;
        end
        count_d = tail_d - head_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= RUN;
            rcnt_q       <= '0;
            recovering_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush_i) begin
                        state_q      <= RECOVER;
                        rcnt_q       <= RCNT_LD;
                        recovering_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    // A fresh flush restarts the window regardless of remaining count.
                    if (flush_i) begin
                        rcnt_q       <= RCNT_LD;
                        recovering_q <= 1'b1;
                    end else if (rcnt_q == '0) begin
                        state_q      <= RUN;
                        recovering_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q      <= RUN;
                    rcnt_q       <= '0;
                    recovering_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROB_ALMOST_FULL_EN
    localparam logic [TAG_W:0] AF_LVL = (TAG_W+1)'(ROB_DEPTH - AF_MARGIN);
    logic af_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) af_q <= 1'b0;
        else           af_q <= (count_d >= AF_LVL);
    end

    assign rob_almost_full_o = af_q;
`else
    logic unused_count_d;
    assign unused_count_d = ^count_d;
`endif

    // Occupancy beyond depth means a flush_tag outside the occupied range.
    assert property (@(posedge clk_i) disable iff (!reset_ni) rob_count_o <= DEPTH_C);
    assert property (@(posedge clk_i) disable iff (!reset_ni)
        ROB_DEPTH >= 4 && (ROB_DEPTH & (ROB_DEPTH - 1)) == 0 &&
        RECOVER_CYCLES >= 1 && RECOVER_CYCLES <= 15 &&
        AF_MARGIN >= 0 && AF_MARGIN < ROB_DEPTH);

endmodule
